// File: rtl/writeback_arbiter.sv
// Merges ALU results and FIFO-buffered, lane-extracted load returns onto one regfile write port; 1-cycle grant-to-write latency.
// ALU has priority until a load has waited STARVE_LIMIT ALU grants; loads back-pressure via o_ld_ready when the FIFO is full.
module wb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_arst,
  input  logic          push_vld,
  input  logic [W-1:0]  push_dat,
  input  logic          pop_rdy,
  output logic          head_vld,
  output logic [W-1:0]  head_dat,
  output logic          full,
  output logic [CW-1:0] count
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign full     = (count == CW'(DEPTH));
  assign head_vld = (count != '0);
  assign head_dat = mem[rd_ptr];
  assign push     = push_vld && !full;
  assign pop      = pop_rdy && head_vld;

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module writeback_arbiter #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 5,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                          i_clk,
  input  logic                          i_arst,
  input  logic                          i_alu_valid,
  output logic                          o_alu_ready,
  input  logic [ADDR_WIDTH-1:0]         i_alu_rd,
  input  logic [DATA_WIDTH-1:0]         i_alu_data,
  input  logic                          i_ld_valid,
  output logic                          o_ld_ready,
  input  logic [ADDR_WIDTH-1:0]         i_ld_rd,
  input  logic [DATA_WIDTH-1:0]         i_ld_data,
  input  logic [2:0]                    i_ld_offset,
  input  logic [1:0]                    i_ld_size,
  input  logic                          i_ld_unsigned,
  output logic                          o_write_en_3,
  output logic [ADDR_WIDTH-1:0]         o_addr_3,
  output logic [DATA_WIDTH-1:0]         o_write_data_3,
  output logic [$clog2(FIFO_DEPTH):0]   o_ld_count
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] raw;
    logic [2:0]            offset;
    logic [1:0]            size;
    logic                  uns;
  } ld_ent_t;

  ld_ent_t         ld_in;
  ld_ent_t         ld_head;
  logic            fifo_full;
  logic            fifo_nonempty;
  logic [SW-1:0]   starve_cnt;
  logic [SW-1:0]   starve_nxt;
  logic            force_ld;
  logic            alu_grant;
  logic            ld_grant;
  logic [DATA_WIDTH-1:0] ld_sh;
  logic [DATA_WIDTH-1:0] ld_fmt;

  always_comb begin
    ld_in        = '0;
    ld_in.rd     = i_ld_rd;
    ld_in.raw    = i_ld_data;
    ld_in.offset = i_ld_offset;
    ld_in.size   = i_ld_size;
    ld_in.uns    = i_ld_unsigned;
  end

  wb_fifo #(
    .W     ($bits(ld_ent_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_ld_fifo (
    .i_clk    (i_clk),
    .i_arst   (i_arst),
    .push_vld (i_ld_valid),
    .push_dat (ld_in),
    .pop_rdy  (ld_grant),
    .head_vld (fifo_nonempty),
    .head_dat (ld_head),
    .full     (fifo_full),
    .count    (o_ld_count)
  );

  assign o_ld_ready  = !fifo_full;
  assign force_ld    = fifo_nonempty && (starve_cnt == STARVE_MAX);
  assign o_alu_ready = !force_ld;
  assign alu_grant   = i_alu_valid && !force_ld;
  assign ld_grant    = !alu_grant && fifo_nonempty;

  always_comb begin
    starve_nxt = starve_cnt;
    if (!fifo_nonempty || ld_grant) begin
      starve_nxt = '0;
    end else if (alu_grant && (starve_cnt != STARVE_MAX)) begin
      starve_nxt = starve_cnt + SW'(1);
    end
  end

  // Lane extraction: shift the addressed byte to bit 0, then trim and extend by size.
  always_comb begin
    ld_sh  = ld_head.raw >> {ld_head.offset, 3'b000};
    ld_fmt = ld_sh;
    case (ld_head.size)
      2'd0:    ld_fmt = {{(DATA_WIDTH-8){ld_sh[7] & ~ld_head.uns}}, ld_sh[7:0]};
      2'd1:    ld_fmt = {{(DATA_WIDTH-16){ld_sh[15] & ~ld_head.uns}}, ld_sh[15:0]};
      2'd2:    ld_fmt = {{(DATA_WIDTH-32){ld_sh[31] & ~ld_head.uns}}, ld_sh[31:0]};
      default: ld_fmt = ld_sh;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      starve_cnt     <= '0;
      o_write_en_3   <= 1'b0;
      o_addr_3       <= '0;
      o_write_data_3 <= '0;
    end else begin
      starve_cnt <= starve_nxt;
      if (alu_grant) begin
        o_write_en_3   <= (i_alu_rd != '0);
        o_addr_3       <= i_alu_rd;
        o_write_data_3 <= i_alu_data;
      end else if (ld_grant) begin
        o_write_en_3   <= (ld_head.rd != '0);
        o_addr_3       <= ld_head.rd;
        o_write_data_3 <= ld_fmt;
      end else begin
        o_write_en_3 <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomised scoreboard bench for writeback_arbiter against a queue-based reference model.
module tb_writeback_arbiter;
  localparam int DEPTH = 4;
  localparam int LIMIT = 3;

  logic        clk = 1'b0;
  logic        arst;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [63:0] alu_data;
  logic        ld_valid, ld_ready;
  logic [4:0]  ld_rd;
  logic [63:0] ld_data;
  logic [2:0]  ld_offset;
  logic [1:0]  ld_size;
  logic        ld_unsigned;
  logic        wen;
  logic [4:0]  waddr;
  logic [63:0] wdata;
  logic [2:0]  ld_count;

  writeback_arbiter dut (
    .i_clk(clk), .i_arst(arst),
    .i_alu_valid(alu_valid), .o_alu_ready(alu_ready), .i_alu_rd(alu_rd), .i_alu_data(alu_data),
    .i_ld_valid(ld_valid), .o_ld_ready(ld_ready), .i_ld_rd(ld_rd), .i_ld_data(ld_data),
    .i_ld_offset(ld_offset), .i_ld_size(ld_size), .i_ld_unsigned(ld_unsigned),
    .o_write_en_3(wen), .o_addr_3(waddr), .o_write_data_3(wdata), .o_ld_count(ld_count)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic en; logic [4:0] addr; logic [63:0] data; } exp_t;
  typedef struct { logic [4:0] rd; logic [63:0] val; } mload_t;

  exp_t   exp_q[$];
  mload_t mq[$];
  int     starve = 0;
  int     cyc = 0;
  int     chk_cnt = 0;
  int     pass_cnt = 0;
  bit     mon_en = 0;
  logic [4:0]  last_addr = '0;
  logic [63:0] last_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
  endtask

  function automatic logic [63:0] fmt(input logic [63:0] raw, input logic [2:0] off,
                                      input logic [1:0] size, input logic uns);
    logic [63:0] sh, mask, v;
    int nb;
    sh = raw >> (int'(off) * 8);
    nb = 8 << size;
    if (nb == 64) return sh;
    mask = (64'd1 << nb) - 64'd1;
    v = sh & mask;
    if (!uns && sh[nb-1]) v = v | ~mask;
    return v;
  endfunction

  // Monitor: one comparison per cycle, either a scheduled write/reset result or a hold.
  always @(negedge clk) begin
    if (mon_en) begin
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        chk("missed_result_due", 64'(cyc), 64'(exp_q[0].due));
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wr_en", {63'd0, wen}, {63'd0, e.en});
        chk("wr_addr", {59'd0, waddr}, {59'd0, e.addr});
        chk("wr_data", wdata, e.data);
        last_addr = e.addr;
        last_data = e.data;
      end else begin
        chk("idle_hold", {wen, waddr, wdata[57:0]}, {1'b0, last_addr, last_data[57:0]});
      end
    end
  end

  task automatic step(input logic rst, input logic av, input logic [4:0] ard, input logic [63:0] ad,
                      input logic lv, input logic [4:0] lrd, input logic [63:0] ldat,
                      input logic [2:0] lo, input logic [1:0] ls, input logic lu);
    int  n;
    bit  frc;
    @(negedge clk);
    arst = rst; alu_valid = av; alu_rd = ard; alu_data = ad;
    ld_valid = lv; ld_rd = lrd; ld_data = ldat; ld_offset = lo; ld_size = ls; ld_unsigned = lu;
    n   = mq.size();
    frc = (n > 0) && (starve == LIMIT);
    chk("ld_ready", {63'd0, ld_ready}, {63'd0, n < DEPTH});
    chk("alu_ready", {63'd0, alu_ready}, {63'd0, !frc});
    chk("ld_count", {61'd0, ld_count}, 64'(n));
    if (rst) begin
      mq.delete();
      starve = 0;
      exp_q.push_back('{cyc + 1, 1'b0, 5'd0, 64'd0});
      return;
    end
    if (av && !frc) begin
      exp_q.push_back('{cyc + 1, ard != 0, ard, ad});
      starve = (n == 0) ? 0 : ((starve < LIMIT) ? starve + 1 : LIMIT);
    end else if (n > 0) begin
      mload_t m;
      m = mq.pop_front();
      exp_q.push_back('{cyc + 1, m.rd != 0, m.rd, m.val});
      starve = 0;
    end else begin
      starve = 0;
    end
    if (lv && n < DEPTH) mq.push_back('{lrd, fmt(ldat, lo, ls, lu)});
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    arst = 1; alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0; ld_offset = 0; ld_size = 0; ld_unsigned = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst = 0;
    chk("rst_wen", {63'd0, wen}, 64'd0);
    chk("rst_addr", {59'd0, waddr}, 64'd0);
    chk("rst_data", wdata, 64'd0);
    chk("rst_count", {61'd0, ld_count}, 64'd0);
    mon_en = 1;

    // ALU only
    step(0, 1, 5'd5, 64'h1234, 0, 0, 0, 0, 0, 0);
    idle();
    // load formatting, signed then unsigned byte at offset 1
    step(0, 0, 0, 0, 1, 5'd7, 64'h8F00, 3'd1, 2'd0, 1'b0);
    repeat (3) idle();
    step(0, 0, 0, 0, 1, 5'd7, 64'h8F00, 3'd1, 2'd0, 1'b1);
    repeat (3) idle();
    // starvation: one load, ALU valid every cycle
    step(0, 1, 5'd1, 64'hA1, 1, 5'd9, 64'hFFEE_DDCC_BBAA_9988, 3'd2, 2'd1, 1'b0);
    for (int i = 0; i < 6; i++) step(0, 1, 5'(10 + i), 64'(100 + i), 0, 0, 0, 0, 0, 0);
    idle();
    // fill the FIFO while the ALU holds the port
    for (int i = 0; i < 8; i++)
      step(0, 1, 5'(20 + i), 64'(200 + i), 1, 5'(1 + i), 64'h8000_0001_7FFF_FF80 + 64'(i), 3'(i), 2'(i), 1'(i));
    repeat (8) idle();
    // writes to x0
    step(0, 1, 5'd0, 64'hDEAD, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 5'd0, 64'h55, 3'd0, 2'd3, 1'b0);
    repeat (3) idle();
    // reset with loads queued and an ALU grant pending
    for (int i = 0; i < 3; i++)
      step(0, 1, 5'(3 + i), 64'(30 + i), 1, 5'(12 + i), 64'hCAFE + 64'(i), 3'd0, 2'd3, 1'b0);
    step(1, 1, 5'd6, 64'h66, 1, 5'd15, 64'hBAD, 3'd0, 2'd3, 1'b0);
    repeat (4) idle();
    // randomised traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 9) < 7), 5'($urandom_range(0, 31)), {$urandom, $urandom},
           ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)), {$urandom, $urandom},
           3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 50 && mq.size() > 0; i++) idle();
    repeat (3) idle();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    mon_en = 0;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
